// File: rtl/wave_cmd_pkg.sv
// Shared constants for the waveform command controller.
// Holds the ASCII opcodes, reply bytes, waveform codes, the argument
// limit for the frequency command and the command FSM state type.
package wave_cmd_pkg;

  localparam logic [7:0] OP_TRIANGLE  = 8'h54;  // 'T'
  localparam logic [7:0] OP_SAWTOOTH  = 8'h53;  // 'S'
  localparam logic [7:0] OP_SQUARE    = 8'h51;  // 'Q'
  localparam logic [7:0] OP_SINE      = 8'h57;  // 'W'
  localparam logic [7:0] OP_NOISE_ON  = 8'h4E;  // 'N'
  localparam logic [7:0] OP_NOISE_OFF = 8'h46;  // 'F'
  localparam logic [7:0] OP_RATE      = 8'h52;  // 'R'
  localparam logic [7:0] OP_STATUS    = 8'h3F;  // '?'

  localparam logic [7:0] REPLY_K = 8'h4B;
  localparam logic [7:0] REPLY_E = 8'h45;

  localparam logic [2:0] WAVE_TRIANGLE = 3'b000;
  localparam logic [2:0] WAVE_SAWTOOTH = 3'b001;
  localparam logic [2:0] WAVE_SQUARE   = 3'b010;
  localparam logic [2:0] WAVE_SINE     = 3'b011;

  localparam logic [7:0] FREQ_MAX = 8'd63;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARG    = 2'd1,
    REPLY1 = 2'd2,
    REPLY2 = 2'd3
  } cmd_state_t;

endpackage

// File: rtl/wave_cfg_shadow.sv
// Shadow/live configuration registers for the waveform generator.
// Writes land in the shadow; the live controls load the whole shadow
// at a phase wrap so the generator never sees a mid-period change.
// Ports:
//   clk, rst                 clock, async active-high reset
//   wr_wave/wave_in          shadow waveform write strobe and value
//   wr_freq/freq_in          shadow frequency write strobe and value
//   wr_noise/noise_in        shadow noise-enable write strobe and value
//   phase_wrap               generator phase accumulator wrap pulse
//   wave_select, freq_select, white_noise_en   live controls
//   cfg_pending              shadow differs from live
module wave_cfg_shadow
  import wave_cmd_pkg::*;
#(
  parameter int WAVE_W = 3,
  parameter int FREQ_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_wave,
  input  logic [WAVE_W-1:0] wave_in,
  input  logic              wr_freq,
  input  logic [FREQ_W-1:0] freq_in,
  input  logic              wr_noise,
  input  logic              noise_in,
  input  logic              phase_wrap,
  output logic [WAVE_W-1:0] wave_select,
  output logic [FREQ_W-1:0] freq_select,
  output logic              white_noise_en,
  output logic              cfg_pending
);

  logic [WAVE_W-1:0] sh_wave, sh_wave_nxt;
  logic [FREQ_W-1:0] sh_freq, sh_freq_nxt;
  logic              sh_noise, sh_noise_nxt;
  logic              differs_nxt;

  // Post-write shadow, so a write and a wrap in the same cycle apply
  // the new value at that wrap.
  always_comb begin
    sh_wave_nxt  = wr_wave  ? wave_in  : sh_wave;
    sh_freq_nxt  = wr_freq  ? freq_in  : sh_freq;
    sh_noise_nxt = wr_noise ? noise_in : sh_noise;
    differs_nxt  = (sh_wave_nxt != wave_select) ||
                   (sh_freq_nxt != freq_select) ||
                   (sh_noise_nxt != white_noise_en);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_wave        <= WAVE_W'(WAVE_TRIANGLE);
      sh_freq        <= '0;
      sh_noise       <= 1'b0;
      wave_select    <= WAVE_W'(WAVE_TRIANGLE);
      freq_select    <= '0;
      white_noise_en <= 1'b0;
      cfg_pending    <= 1'b0;
    end else begin
      sh_wave  <= sh_wave_nxt;
      sh_freq  <= sh_freq_nxt;
      sh_noise <= sh_noise_nxt;
      // With nothing pending the shadow already equals live, so a bare
      // wrap reloads identical values and is a no-op.
      if (phase_wrap) begin
        wave_select    <= sh_wave_nxt;
        freq_select    <= sh_freq_nxt;
        white_noise_en <= sh_noise_nxt;
        cfg_pending    <= 1'b0;
      end else begin
        cfg_pending <= differs_nxt;
      end
    end
  end

endmodule

// File: rtl/wave_cmd_controller.sv
// UART command sequencer for the waveform generator.
// Parses command bytes into the shadow configuration, returns K/E or
// two-byte status replies over a valid/ready handshake, and times out
// a missing frequency argument.
// Ports:
//   clk, rst            clock, async active-high reset
//   rx_data, rx_valid   received byte and its one-cycle strobe
//   phase_wrap          generator phase wrap pulse
//   tx_data, tx_valid, tx_ready   reply byte handshake
//   wave_select, freq_select, white_noise_en   live generator controls
//   cfg_pending         shadow awaiting a phase wrap
//   cmd_error           one-cycle pulse per rejected or dropped byte
//
// state  | meaning
// IDLE   | waiting for an opcode byte
// ARG    | 'R' seen, waiting for frequency argument (timed)
// REPLY1 | first (or only) reply byte offered
// REPLY2 | second status byte (live frequency) offered
module wave_cmd_controller
  import wave_cmd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 2500000,
  parameter int FREQ_W         = 6,
  parameter int WAVE_W         = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic              phase_wrap,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [WAVE_W-1:0] wave_select,
  output logic [FREQ_W-1:0] freq_select,
  output logic              white_noise_en,
  output logic              cfg_pending,
  output logic              cmd_error
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

  cmd_state_t        state;
  logic [CNT_W-1:0]  arg_cnt;
  logic              status_reply;

  logic              wr_wave, wr_freq, wr_noise, noise_in;
  logic [WAVE_W-1:0] wave_in;
  logic              arg_ok;

  assign arg_ok = (rx_data <= FREQ_MAX);

  always_comb begin
    wr_wave  = 1'b0;
    wave_in  = WAVE_W'(WAVE_TRIANGLE);
    wr_noise = 1'b0;
    noise_in = 1'b0;
    wr_freq  = 1'b0;
    if (state == IDLE && rx_valid) begin
      case (rx_data)
        OP_TRIANGLE:  begin wr_wave = 1'b1; wave_in = WAVE_W'(WAVE_TRIANGLE); end
        OP_SAWTOOTH:  begin wr_wave = 1'b1; wave_in = WAVE_W'(WAVE_SAWTOOTH); end
        OP_SQUARE:    begin wr_wave = 1'b1; wave_in = WAVE_W'(WAVE_SQUARE);   end
        OP_SINE:      begin wr_wave = 1'b1; wave_in = WAVE_W'(WAVE_SINE);     end
        OP_NOISE_ON:  begin wr_noise = 1'b1; noise_in = 1'b1; end
        OP_NOISE_OFF: begin wr_noise = 1'b1; noise_in = 1'b0; end
        default: ;
      endcase
    end
    if (state == ARG && rx_valid && arg_ok) wr_freq = 1'b1;
  end

  wave_cfg_shadow #(
    .WAVE_W(WAVE_W),
    .FREQ_W(FREQ_W)
  ) u_shadow (
    .clk            (clk),
    .rst            (rst),
    .wr_wave        (wr_wave),
    .wave_in        (wave_in),
    .wr_freq        (wr_freq),
    .freq_in        (rx_data[FREQ_W-1:0]),
    .wr_noise       (wr_noise),
    .noise_in       (noise_in),
    .phase_wrap     (phase_wrap),
    .wave_select    (wave_select),
    .freq_select    (freq_select),
    .white_noise_en (white_noise_en),
    .cfg_pending    (cfg_pending)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      arg_cnt      <= '0;
      status_reply <= 1'b0;
      tx_valid     <= 1'b0;
      tx_data      <= 8'h00;
      cmd_error    <= 1'b0;
    end else begin
      cmd_error <= 1'b0;
      case (state)
        IDLE: begin
          arg_cnt <= '0;
          if (rx_valid) begin
            status_reply <= 1'b0;
            state        <= REPLY1;
            tx_valid     <= 1'b1;
            case (rx_data)
              OP_TRIANGLE, OP_SAWTOOTH, OP_SQUARE, OP_SINE,
              OP_NOISE_ON, OP_NOISE_OFF: tx_data <= REPLY_K;
              OP_RATE: begin
                state    <= ARG;
                tx_valid <= 1'b0;
              end
              OP_STATUS: begin
                status_reply <= 1'b1;
                tx_data      <= 8'({white_noise_en, wave_select});
              end
              default: begin
                tx_data   <= REPLY_E;
                cmd_error <= 1'b1;
              end
            endcase
          end
        end
        ARG: begin
          if (rx_valid) begin
            arg_cnt  <= '0;
            state    <= REPLY1;
            tx_valid <= 1'b1;
            if (arg_ok) begin
              tx_data <= REPLY_K;
            end else begin
              tx_data   <= REPLY_E;
              cmd_error <= 1'b1;
            end
          end else if (arg_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            arg_cnt   <= '0;
            state     <= REPLY1;
            tx_valid  <= 1'b1;
            tx_data   <= REPLY_E;
            cmd_error <= 1'b1;
          end else begin
            arg_cnt <= arg_cnt + 1'b1;
          end
        end
        REPLY1: begin
          if (rx_valid) cmd_error <= 1'b1;
          if (tx_ready) begin
            if (status_reply) begin
              state   <= REPLY2;
              tx_data <= 8'(freq_select);
            end else begin
              state    <= IDLE;
              tx_valid <= 1'b0;
            end
          end
        end
        REPLY2: begin
          if (rx_valid) cmd_error <= 1'b1;
          if (tx_ready) begin
            state        <= IDLE;
            tx_valid     <= 1'b0;
            status_reply <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wave_cmd_controller.sv
module tb_wave_cmd_controller;
  import wave_cmd_pkg::*;

  localparam int T = 20;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       phase_wrap;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [2:0] wave_select;
  logic [5:0] freq_select;
  logic       white_noise_en;
  logic       cfg_pending;
  logic       cmd_error;

  int n_cmp = 0;
  int n_err = 0;
  int waited;

  wave_cmd_controller #(.TIMEOUT_CYCLES(T), .FREQ_W(6), .WAVE_W(3)) dut (
    .clk            (clk),
    .rst            (rst),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .phase_wrap     (phase_wrap),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .wave_select    (wave_select),
    .freq_select    (freq_select),
    .white_noise_en (white_noise_en),
    .cfg_pending    (cfg_pending),
    .cmd_error      (cmd_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // All tasks start and end just after a falling edge.
  task automatic send_byte(input logic [7:0] b);
    rx_data = b; rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic pulse_wrap();
    phase_wrap = 1'b1;
    @(negedge clk);
    phase_wrap = 1'b0;
  endtask

  task automatic take_reply(input string tag, input logic [7:0] exp);
    check({tag, "_valid"}, tx_valid, 1);
    check({tag, "_data"}, tx_data, exp);
    tx_ready = 1'b1;
    @(negedge clk);
    tx_ready = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wave"}, wave_select, 0);
    check({tag, "_freq"}, freq_select, 0);
    check({tag, "_noise"}, white_noise_en, 0);
    check({tag, "_txv"}, tx_valid, 0);
    check({tag, "_txd"}, tx_data, 8'h00);
    check({tag, "_pend"}, cfg_pending, 0);
    check({tag, "_err"}, cmd_error, 0);
  endtask

  initial begin
    rst = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; phase_wrap = 1'b0; tx_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    rst = 1'b0;
    @(negedge clk);

    // 'S' held off until a wrap
    send_byte(OP_SAWTOOTH);
    check("s_pend", cfg_pending, 1);
    take_reply("s_reply", REPLY_K);
    check("s_wave_hold", wave_select, 3'b000);
    check("s_pend_hold", cfg_pending, 1);
    pulse_wrap();
    check("s_wave_applied", wave_select, 3'b001);
    check("s_pend_clr", cfg_pending, 0);

    // 'R' 0x3C
    send_byte(OP_RATE);
    check("r_in_arg", tx_valid, 0);
    send_byte(8'h3C);
    take_reply("r60_reply", REPLY_K);
    check("r60_pend", cfg_pending, 1);
    pulse_wrap();
    check("r60_freq", freq_select, 6'h3C);

    // 'R' out-of-range argument
    send_byte(OP_RATE);
    send_byte(8'h50);
    check("r80_err", cmd_error, 1);
    take_reply("r80_reply", REPLY_E);
    check("r80_err_pulse", cmd_error, 0);
    check("r80_freq", freq_select, 6'h3C);
    check("r80_pend", cfg_pending, 0);

    // 'R' with no argument times out
    send_byte(OP_RATE);
    waited = 0;
    for (int i = 1; i <= T + 20; i++) begin
      @(negedge clk);
      if (tx_valid) begin waited = i; break; end
    end
    check("tmo_cycles", waited, T);
    check("tmo_err", cmd_error, 1);
    take_reply("tmo_reply", REPLY_E);
    check("tmo_idle", tx_valid, 0);

    // 'W' then 'N', one wrap applies both together
    send_byte(OP_SINE);
    take_reply("w_reply", REPLY_K);
    send_byte(OP_NOISE_ON);
    take_reply("n_reply", REPLY_K);
    check("wn_wave_hold", wave_select, 3'b001);
    check("wn_noise_hold", white_noise_en, 0);
    pulse_wrap();
    check("wn_wave", wave_select, 3'b011);
    check("wn_noise", white_noise_en, 1);

    // Status, each byte stalled 5 cycles
    send_byte(OP_STATUS);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stat1_hold_v", tx_valid, 1);
      check("stat1_hold_d", tx_data, 8'h0B);
    end
    take_reply("stat1", 8'h0B);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stat2_hold_v", tx_valid, 1);
      check("stat2_hold_d", tx_data, 8'h3C);
    end
    take_reply("stat2", 8'h3C);
    check("stat_done", tx_valid, 0);

    // Unknown opcode
    send_byte(8'h41);
    check("bad_err", cmd_error, 1);
    take_reply("bad_reply", REPLY_E);

    // Overrun while a reply is stalled
    send_byte(OP_TRIANGLE);
    check("ovr_first", tx_data, REPLY_K);
    send_byte(OP_SAWTOOTH);
    check("ovr_err", cmd_error, 1);
    check("ovr_txv", tx_valid, 1);
    check("ovr_txd", tx_data, REPLY_K);
    take_reply("ovr_reply", REPLY_K);
    check("ovr_pend", cfg_pending, 1);
    pulse_wrap();
    check("ovr_wave", wave_select, 3'b000);
    check("ovr_noise", white_noise_en, 1);

    // Commit coinciding with a wrap
    rx_data = OP_SQUARE; rx_valid = 1'b1; phase_wrap = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0; phase_wrap = 1'b0;
    check("coin_wave", wave_select, 3'b010);
    check("coin_pend", cfg_pending, 0);
    take_reply("coin_reply", REPLY_K);
    check("coin_pend2", cfg_pending, 0);

    // Reset while in ARG
    send_byte(OP_RATE);
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_arg");
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_arg_quiet", tx_valid, 0);

    // Reset while in REPLY2
    send_byte(OP_RATE);
    send_byte(8'h05);
    take_reply("r5_reply", REPLY_K);
    pulse_wrap();
    check("r5_freq", freq_select, 6'h05);
    send_byte(OP_STATUS);
    take_reply("stat_b1", 8'h00);
    check("stat_b2", tx_data, 8'h05);
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_rep2");
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_rep2_quiet", tx_valid, 0);

    // Commit equal to live value
    send_byte(OP_TRIANGLE);
    check("same_pend", cfg_pending, 0);
    take_reply("same_reply", REPLY_K);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
